// File: rtl/ifetch_unit_if.sv
// ============================================================================
// Module   : ifetch_unit_if
// Purpose  : Bundles the EX-stage redirect inputs, BRAM port and IF/ID outputs
//            of the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ifetch_unit_if;
  logic        stall;
  logic        ex_branch;
  logic        ex_zero;
  logic        ex_jal;
  logic        ex_jalr;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm32;
  logic [31:0] ex_rs1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] redirect_cnt;
  logic [31:0] fetch_cnt;

  modport slave (
    input  stall, ex_branch, ex_zero, ex_jal, ex_jalr, ex_pc, ex_imm32, ex_rs1,
           imem_rdata,
    output imem_addr, pc, redirect, if_id_pc, if_id_inst, if_id_pc4,
           if_id_valid, redirect_cnt, fetch_cnt
  );

  modport master (
    output stall, ex_branch, ex_zero, ex_jal, ex_jalr, ex_pc, ex_imm32, ex_rs1,
           imem_rdata,
    input  imem_addr, pc, redirect, if_id_pc, if_id_inst, if_id_pc4,
           if_id_valid, redirect_cnt, fetch_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module   : ifetch_unit
// Purpose  : PC register, BRAM address generation, EX redirects and the IF/ID
//            pipeline register with stall/flush handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ifetch_unit_if.slave      fetch_if
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_inst_q;
  logic [31:0] if_id_pc4_q;
  logic        if_id_valid_q;
  logic [31:0] redirect_cnt_q;
  logic [31:0] fetch_cnt_q;

  logic        w_take;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_take     = fetch_if.ex_jal | fetch_if.ex_jalr |
                      (fetch_if.ex_branch & fetch_if.ex_zero);
  assign w_redirect = w_take & ~rst;
  assign w_pc_plus4 = pc_q + 32'd4;

  // JALR wins if both jump flags are raised; only bit 0 is cleared.
  assign w_target = fetch_if.ex_jalr
                  ? ((fetch_if.ex_rs1 + fetch_if.ex_imm32) & 32'hFFFF_FFFE)
                  : (fetch_if.ex_pc + fetch_if.ex_imm32);

  // The BRAM address is always the next PC, so imem_rdata tracks pc_q.
  always_comb begin
    pc_d = w_pc_plus4;
    if (rst)                 pc_d = RESET_PC;
    else if (w_redirect)     pc_d = w_target;
    else if (fetch_if.stall) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= 32'd0;
      if_id_inst_q   <= 32'd0;
      if_id_pc4_q    <= 32'd0;
      if_id_valid_q  <= 1'b0;
      redirect_cnt_q <= 32'd0;
      fetch_cnt_q    <= 32'd0;
    end else if (w_redirect) begin
      pc_q           <= pc_d;
      if_id_valid_q  <= 1'b0;
      redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end else if (!fetch_if.stall) begin
      pc_q          <= pc_d;
      if_id_pc_q    <= pc_q;
      if_id_inst_q  <= fetch_if.imem_rdata;
      if_id_pc4_q   <= w_pc_plus4;
      if_id_valid_q <= 1'b1;
      fetch_cnt_q   <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_if.imem_addr    = pc_d;
  assign fetch_if.pc           = pc_q;
  assign fetch_if.redirect     = w_redirect;
  assign fetch_if.if_id_pc     = if_id_pc_q;
  assign fetch_if.if_id_inst   = if_id_inst_q;
  assign fetch_if.if_id_pc4    = if_id_pc4_q;
  assign fetch_if.if_id_valid  = if_id_valid_q;
  assign fetch_if.redirect_cnt = redirect_cnt_q;
  assign fetch_if.fetch_cnt    = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Directed vector table plus randomized run against a reference
//            model for ifetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous BRAM: one-cycle read latency.
  always @(posedge clk) bus.imem_rdata <= memword(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic z, input logic jal,
                       input logic jalr, input logic [31:0] epc, input logic [31:0] imm,
                       input logic [31:0] rs1);
    bus.stall     = st;
    bus.ex_branch = br;
    bus.ex_zero   = z;
    bus.ex_jal    = jal;
    bus.ex_jalr   = jalr;
    bus.ex_pc     = epc;
    bus.ex_imm32  = imm;
    bus.ex_rs1    = rs1;
  endtask

  typedef struct {
    logic        st, br, z, jal, jalr;
    logic [31:0] epc, imm, rs1;
    logic        e_red;
    logic [31:0] e_addr, e_pc, e_ifpc;
    logic        chk_if, e_valid;
    logic [31:0] e_fc, e_rc;
  } vec_t;

  vec_t vecs[23];

  // Reference model state, advanced by the fetch-stage rules.
  logic [31:0] m_pc, m_ifpc, m_inst, m_pc4, m_rc, m_fc;
  logic        m_valid;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //            st br z jal jalr epc           imm           rs1          red addr          pc            ifpc          chk v  fc     rc
    vecs[0]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h4,        32'h4,        32'h0,        1,1, 32'd1, 32'd0};
    vecs[1]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h8,        32'h8,        32'h4,        1,1, 32'd2, 32'd0};
    vecs[2]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'hC,        32'hC,        32'h8,        1,1, 32'd3, 32'd0};
    vecs[3]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h10,       32'h10,       32'hC,        1,1, 32'd4, 32'd0};
    vecs[4]  = '{0,1,1,0,0, 32'h10,       32'hFFFFFFF8, 32'h0,    1, 32'h8,        32'h8,        32'h0,        0,0, 32'd4, 32'd1};
    vecs[5]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'hC,        32'hC,        32'h8,        1,1, 32'd5, 32'd1};
    vecs[6]  = '{0,1,0,0,0, 32'h40,       32'h100,      32'h0,    0, 32'h10,       32'h10,       32'hC,        1,1, 32'd6, 32'd1};
    vecs[7]  = '{0,0,0,0,1, 32'h500,      32'h4,        32'h101,  1, 32'h104,      32'h104,      32'h0,        0,0, 32'd6, 32'd2};
    vecs[8]  = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h108,      32'h108,      32'h104,      1,1, 32'd7, 32'd2};
    vecs[9]  = '{0,0,0,1,0, 32'h8,        32'h14,       32'h0,    1, 32'h1C,       32'h1C,       32'h0,        0,0, 32'd7, 32'd3};
    vecs[10] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h20,       32'h20,       32'h1C,       1,1, 32'd8, 32'd3};
    vecs[11] = '{1,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h20,       32'h20,       32'h1C,       1,1, 32'd8, 32'd3};
    vecs[12] = '{1,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h20,       32'h20,       32'h1C,       1,1, 32'd8, 32'd3};
    vecs[13] = '{1,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h20,       32'h20,       32'h1C,       1,1, 32'd8, 32'd3};
    vecs[14] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h24,       32'h24,       32'h20,       1,1, 32'd9, 32'd3};
    vecs[15] = '{1,0,0,1,0, 32'h200,      32'h40,       32'h0,    1, 32'h240,      32'h240,      32'h0,        0,0, 32'd9, 32'd4};
    vecs[16] = '{1,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h240,      32'h240,      32'h0,        0,0, 32'd9, 32'd4};
    vecs[17] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h244,      32'h244,      32'h240,      1,1, 32'd10, 32'd4};
    vecs[18] = '{0,0,0,1,1, 32'h0,        32'h10,       32'h3003, 1, 32'h3012,     32'h3012,     32'h0,        0,0, 32'd10, 32'd5};
    vecs[19] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h3016,     32'h3016,     32'h3012,     1,1, 32'd11, 32'd5};
    vecs[20] = '{0,1,1,0,0, 32'hFFFFFFF0, 32'hC,        32'h0,    1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        0,0, 32'd11, 32'd6};
    vecs[21] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h0,        32'h0,        32'hFFFFFFFC, 1,1, 32'd12, 32'd6};
    vecs[22] = '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,    0, 32'h4,        32'h4,        32'h0,        1,1, 32'd13, 32'd6};

    // Reset with a JAL pending: reset must win.
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 32'h80, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    @(posedge clk); #1;
    chk("rst_pc", bus.pc, RESET_PC);
    chk("rst_if_id_pc", bus.if_id_pc, 32'd0);
    chk("rst_if_id_inst", bus.if_id_inst, 32'd0);
    chk("rst_if_id_pc4", bus.if_id_pc4, 32'd0);
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("rst_redirect_cnt", bus.redirect_cnt, 32'd0);
    chk("rst_fetch_cnt", bus.fetch_cnt, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].z, vecs[i].jal, vecs[i].jalr,
            vecs[i].epc, vecs[i].imm, vecs[i].rs1);
      @(negedge clk);
      chk($sformatf("v%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, vecs[i].e_red});
      chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].e_pc);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.if_id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_fetch_cnt", i), bus.fetch_cnt, vecs[i].e_fc);
      chk($sformatf("v%0d_redirect_cnt", i), bus.redirect_cnt, vecs[i].e_rc);
      if (vecs[i].chk_if) begin
        chk($sformatf("v%0d_if_id_pc", i), bus.if_id_pc, vecs[i].e_ifpc);
        chk($sformatf("v%0d_if_id_pc4", i), bus.if_id_pc4, vecs[i].e_ifpc + 32'd4);
        chk($sformatf("v%0d_if_id_inst", i), bus.if_id_inst, memword(vecs[i].e_ifpc));
      end
    end

    // Mid-operation reset together with stall and JAL.
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 32'h900, 32'h20, 32'h0);
    @(negedge clk);
    chk("mid_rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("mid_rst_imem_addr", bus.imem_addr, RESET_PC);
    @(posedge clk); #1;
    chk("mid_rst_pc", bus.pc, RESET_PC);
    chk("mid_rst_redirect_cnt", bus.redirect_cnt, 32'd0);
    chk("mid_rst_fetch_cnt", bus.fetch_cnt, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("post_rst_if_id_pc", bus.if_id_pc, RESET_PC);
    chk("post_rst_if_id_inst", bus.if_id_inst, memword(RESET_PC));

    // Randomized run; first cycle forces reset to align the model.
    for (int c = 0; c < 600; c++) begin
      logic        r_st, r_br, r_z, r_jal, r_jalr, take, e_red;
      logic [31:0] r_pc, r_imm, r_rs1, tgt, e_addr;
      int          sel;
      rst  = (c == 0) || ($urandom_range(0, 39) == 0);
      r_st = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 9);
      r_jal  = (sel == 0) || (sel == 9 && $urandom_range(0, 3) == 0);
      r_jalr = (sel == 1) || (sel == 9 && $urandom_range(0, 3) == 0);
      r_br   = (sel == 2) || (sel == 3);
      r_z    = $urandom_range(0, 1) == 1;
      r_pc   = $urandom;
      r_imm  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 511)) - 256);
      r_rs1  = $urandom;
      drive(r_st, r_br, r_z, r_jal, r_jalr, r_pc, r_imm, r_rs1);

      take   = r_jal || r_jalr || (r_br && r_z);
      e_red  = take && !rst;
      tgt    = r_jalr ? ((r_rs1 + r_imm) & ~32'd1) : (r_pc + r_imm);
      e_addr = rst ? RESET_PC : (e_red ? tgt : (r_st ? m_pc : m_pc + 32'd4));

      @(negedge clk);
      chk("rnd_redirect", {31'd0, bus.redirect}, {31'd0, e_red});
      if (c != 0) chk("rnd_imem_addr", bus.imem_addr, e_addr);

      if (rst) begin
        m_pc = RESET_PC; m_ifpc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_rc = 0; m_fc = 0;
      end else if (e_red) begin
        m_pc = tgt; m_valid = 0; m_rc = m_rc + 1;
      end else if (!r_st) begin
        m_ifpc = m_pc; m_inst = memword(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4; m_fc = m_fc + 1;
      end

      @(posedge clk); #1;
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
      chk("rnd_redirect_cnt", bus.redirect_cnt, m_rc);
      chk("rnd_fetch_cnt", bus.fetch_cnt, m_fc);
      if (m_valid || rst) begin
        chk("rnd_if_id_pc", bus.if_id_pc, m_ifpc);
        chk("rnd_if_id_inst", bus.if_id_inst, m_inst);
        chk("rnd_if_id_pc4", bus.if_id_pc4, m_pc4);
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
